// File: rtl/dru_lane_sched.sv
// dru_lane_sched: pairs per-lane recovery nibbles into bytes, buffers each lane
// in a small FIFO, and shares one byte-wide tagged output among all lanes with
// round-robin arbitration.
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_lane_d/stb/sof          per-lane nibble, strobe, start-of-burst qualifier
//   o_out_d/lane/sof/valid    output byte, source lane, first-of-burst, valid
//   i_out_ready               consumer accepts when o_out_valid & i_out_ready
//   o_ovf, o_frag             sticky per-lane overflow / odd-nibble flags
//   i_flag_clr                clears o_ovf and o_frag (a same-cycle set wins)
module dru_lane_sched #(
    parameter int unsigned NLANES = 4,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [4*NLANES-1:0]         i_lane_d,
    input  logic [NLANES-1:0]           i_lane_stb,
    input  logic [NLANES-1:0]           i_lane_sof,
    output logic [7:0]                  o_out_d,
    output logic [$clog2(NLANES)-1:0]   o_out_lane,
    output logic                        o_out_sof,
    output logic                        o_out_valid,
    input  logic                        i_out_ready,
    output logic [NLANES-1:0]           o_ovf,
    output logic [NLANES-1:0]           o_frag,
    input  logic                        i_flag_clr
);

    localparam int unsigned LW = $clog2(NLANES);
    localparam int unsigned AW = $clog2(DEPTH);

    // Lane index base+off, wrapping modulo NLANES.
    function automatic logic [LW-1:0] lane_at(input logic [LW-1:0] base, input int unsigned off);
        return LW'((32'(base) + off) % NLANES);
    endfunction

    logic [NLANES-1:0] r_ph;
    logic [NLANES-1:0] r_psof;
    logic [3:0]        r_hi  [NLANES];
    logic [AW:0]       r_wp  [NLANES];
    logic [AW:0]       r_rp  [NLANES];
    logic [8:0]        r_mem [NLANES][DEPTH];
    logic [LW-1:0]     r_rr;

    logic [NLANES-1:0] w_empty;
    logic [NLANES-1:0] w_full;
    logic [NLANES-1:0] w_push;
    logic [NLANES-1:0] w_frag_set;
    logic [NLANES-1:0] w_pop;
    logic [NLANES-1:0] w_wr;
    logic [NLANES-1:0] w_ovf_set;
    logic [8:0]        w_rdata [NLANES];
    logic              w_adv;
    logic              w_found;
    logic [LW-1:0]     w_gnt;

    // Per-lane FIFO status and packer events.
    always_comb begin
        for (int k = 0; k < int'(NLANES); k++) begin
            w_empty[k]    = (r_wp[k] == r_rp[k]);
            w_full[k]     = (r_wp[k][AW] != r_rp[k][AW]) &&
                            (r_wp[k][AW-1:0] == r_rp[k][AW-1:0]);
            w_push[k]     = i_lane_stb[k] & r_ph[k] & ~i_lane_sof[k];
            w_frag_set[k] = i_lane_stb[k] & r_ph[k] &  i_lane_sof[k];
            w_rdata[k]    = r_mem[k][r_rp[k][AW-1:0]];
        end
    end

    // Round-robin grant: first non-empty lane at or after r_rr.
    always_comb begin
        w_adv   = ~o_out_valid | i_out_ready;
        w_found = 1'b0;
        w_gnt   = '0;
        w_pop   = '0;
        for (int unsigned i = 0; i < NLANES; i++) begin
            if (!w_found && !w_empty[lane_at(r_rr, i)]) begin
                w_found = 1'b1;
                w_gnt   = lane_at(r_rr, i);
            end
        end
        if (w_adv && w_found) begin
            w_pop[w_gnt] = 1'b1;
        end
    end

    // A push into a full FIFO is accepted only if the same lane pops this cycle.
    always_comb begin
        w_wr      = w_push & (~w_full | w_pop);
        w_ovf_set = w_push & w_full & ~w_pop;
    end

    // Packers and FIFO pointers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ph   <= '0;
            r_psof <= '0;
            for (int k = 0; k < int'(NLANES); k++) begin
                r_hi[k] <= '0;
                r_wp[k] <= '0;
                r_rp[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(NLANES); k++) begin
                if (i_lane_stb[k]) begin
                    // A sof nibble always restarts pairing, discarding a held half.
                    if (!r_ph[k] || i_lane_sof[k]) begin
                        r_hi[k]   <= i_lane_d[4*k +: 4];
                        r_psof[k] <= i_lane_sof[k];
                        r_ph[k]   <= 1'b1;
                    end else begin
                        r_ph[k]   <= 1'b0;
                    end
                end
                if (w_wr[k]) begin
                    r_wp[k] <= r_wp[k] + (AW+1)'(1);
                end
                if (w_pop[k]) begin
                    r_rp[k] <= r_rp[k] + (AW+1)'(1);
                end
            end
        end
    end

    // FIFO storage; contents are don't-care while pointers mark it empty.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < int'(NLANES); k++) begin
            if (w_wr[k]) begin
                r_mem[k][r_wp[k][AW-1:0]] <= {r_psof[k], r_hi[k], i_lane_d[4*k +: 4]};
            end
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_out_valid <= 1'b0;
            o_out_d     <= '0;
            o_out_lane  <= '0;
            o_out_sof   <= 1'b0;
            r_rr        <= '0;
        end else if (w_adv) begin
            if (w_found) begin
                o_out_valid <= 1'b1;
                o_out_d     <= w_rdata[w_gnt][7:0];
                o_out_sof   <= w_rdata[w_gnt][8];
                o_out_lane  <= w_gnt;
                r_rr        <= lane_at(w_gnt, 32'd1);
            end else begin
                o_out_valid <= 1'b0;
            end
        end
    end

    // Sticky flags; a set event overrides a same-cycle clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ovf  <= '0;
            o_frag <= '0;
        end else begin
            o_ovf  <= (i_flag_clr ? '0 : o_ovf)  | w_ovf_set;
            o_frag <= (i_flag_clr ? '0 : o_frag) | w_frag_set;
        end
    end

endmodule
